storebuffer: RTL and testbench
==============================

# storebuffer

Posted-write buffer between the core data port and data memory: the write-direction counterpart of the instruction fetch buffer. Stores are acknowledged as soon as they are queued, then drained to memory in order, one transaction at a time. Loads bypass the queue unless they hit a queued word, in which case the queue drains first. Fences drain the queue and are then forwarded to memory.

## Interface
- storebuffer_depth, 2 (from configure), log2 of entry count (4 entries).
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- storebuffer_in  in  mem_in_type  core data request (mem_valid, mem_fence, mem_instr, mem_addr, mem_wdata, mem_wstrb).
- storebuffer_out  out  mem_out_type  core response (mem_rdata, mem_ready).
- dmem_out  in  mem_out_type  memory response.
- dmem_in  out  mem_in_type  memory request.

## Operation
- Core request is a one-cycle mem_valid pulse. It is latched into a pending register until answered. Exactly one core request is outstanding; the core does not pulse again before mem_ready.
- Request class:
  - mem_fence=1: fence.
  - mem_wstrb≠0: store.
  - otherwise: load.
- Entry = {addr[31:2], wdata[31:0], wstrb[3:0]}.
- Queue state: wptr and rptr (storebuffer_depth bits, wrap modulo 2**depth) and count (depth+1 bits, 0..2**depth).
- Store: if count<2**depth, write the entry at wptr and increment wptr and count. If full, hold the store pending.
- Load hit: a valid queued entry has addr[31:2]==mem_addr[31:2]. A hit load waits until no queued entry matches; no forwarding.
- Load miss: issued to memory.
- FSM (dmem side):
  - IDLE: priority is pending miss-load → LOAD, then queue non-empty → STORE, then pending fence with count==0 → FENCE.
  - STORE: dmem_in carries the head entry. On dmem_out.mem_ready, increment rptr, decrement count, → IDLE.
  - LOAD: on dmem_out.mem_ready, pass mem_rdata to the core with mem_ready=1 → IDLE.
  - FENCE: dmem_in.mem_fence=1. On dmem_out.mem_ready, core mem_ready=1 → IDLE.
- dmem_in.mem_valid pulses for one cycle on entry to STORE, LOAD or FENCE. One memory transaction is outstanding at a time. mem_instr=0 always.
- Reset mid-operation clears the queue, pending register and FSM. Any in-flight memory ready arriving after reset is ignored.

## Timing
- Reset values:
  - storebuffer_out: mem_ready=0, mem_rdata=0.
  - dmem_in: all fields 0.
  - count, wptr, rptr: 0.
  - FSM: IDLE.
- Store with space: mem_ready is combinational in the same cycle as mem_valid (0-cycle latency). Entry is visible from the next cycle.
- Store into a full queue: mem_ready=1 in the cycle the head store's dmem_out.mem_ready arrives; enqueue and dequeue happen in that same cycle, count unchanged.
- Load miss with the FSM in IDLE: dmem_in.mem_valid=1 in the same cycle as the core pulse. Core mem_ready and rdata appear in the same cycle as dmem_out.mem_ready.
- A load arriving during STORE is issued in the cycle after that store completes.
- Load hit: issued the cycle after the last matching entry retires.
- Store mem_rdata=0. mem_ready is never asserted during a fence except on fence completion.
- Simultaneous store acceptance and head retire: count unchanged, both pointers advance.

## Structure
- Package storebuffer_wires: entry typedef; storebuffer_data_in_type {wen, waddr, wdata(entry), raddr}; storebuffer_data_out_type {rdata(entry), hit vector}; FSM state enum.
- Sub-module storebuffer_data:
  - entry array with one write port and one read port (head);
  - parallel compare of all valid entries against the pending address, producing the hit vector;
  - valid bits come from the ctrl occupancy mask.
- storebuffer_ctrl: FSM, pointers, pending register, muxing.
- storebuffer: top level wiring the two.

## Test plan
- Store 0x1000/0xDEADBEEF/wstrb 0xF with an empty queue → mem_ready in the same cycle. The next cycle, dmem_in.mem_valid=1 with addr 0x1000. After dmem ready, count=0.
- Five back-to-back stores with dmem ready held off → first four acked immediately. The fifth is acked in the cycle of the first dmem ready; memory sees the writes in issue order.
- Store to 0x2000, then a load from 0x2002 → the load is not issued until the store's dmem ready. The following cycle dmem_in is a load to 0x2000 (word 0x2000>>2); rdata is returned on dmem ready.
- Load miss 0x3000 with the queue holding 0x4000 → the load is issued before the queued store drains. Core rdata equals dmem rdata 0x12345678 in the same cycle.
- Fence with three queued stores → three STORE transactions, then dmem_in.mem_fence=1. Core mem_ready only on the fence's dmem ready.
- Assert rst low with two entries queued and a STORE outstanding → all outputs 0 immediately. A later stale dmem ready produces no core mem_ready and count stays 0.

Source files
------------

// File: rtl/storebuffer_pkg.sv
// Shared types for the store buffer: core/memory bus structs, queue entry,
// data-array request/response structs and the dmem-side FSM state.
package storebuffer_wires;

  localparam int storebuffer_depth = 2;
  localparam int sb_entries = 1 << storebuffer_depth;

  typedef struct packed {
    logic        mem_valid;
    logic        mem_fence;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
  } mem_in_type;

  typedef struct packed {
    logic [31:0] mem_rdata;
    logic        mem_ready;
  } mem_out_type;

  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } storebuffer_entry_type;

  typedef struct packed {
    logic                         wen;
    logic [storebuffer_depth-1:0] waddr;
    storebuffer_entry_type        wdata;
    logic [storebuffer_depth-1:0] raddr;
    logic [29:0]                  caddr;
    logic [sb_entries-1:0]        valid;
  } storebuffer_data_in_type;

  typedef struct packed {
    storebuffer_entry_type  rdata;
    logic [sb_entries-1:0]  hit;
  } storebuffer_data_out_type;

  typedef enum logic [1:0] {
    SB_IDLE  = 2'd0,
    SB_STORE = 2'd1,
    SB_LOAD  = 2'd2,
    SB_FENCE = 2'd3
  } storebuffer_state_type;

  // Slot i is occupied when its distance from the head is below the count.
  function automatic logic [sb_entries-1:0] occupancy(
    input logic [storebuffer_depth-1:0] rptr,
    input logic [storebuffer_depth:0]   count
  );
    logic [storebuffer_depth-1:0] off;
    occupancy = '0;
    for (int i = 0; i < sb_entries; i++) begin
      off = storebuffer_depth'(i) - rptr;
      occupancy[i] = ({1'b0, off} < count);
    end
  endfunction

endpackage

// File: rtl/storebuffer_ctrl.sv
// Queue pointers, pending core request and the dmem-side FSM that drains
// stores in order, issues bypassing loads and forwards fences.
module storebuffer_ctrl
  import storebuffer_wires::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  mem_in_type                   storebuffer_in,
  output mem_out_type                  storebuffer_out,
  input  mem_out_type                  dmem_out,
  output mem_in_type                   dmem_in,
  output storebuffer_data_in_type      data_in,
  input  storebuffer_data_out_type     data_out,
  output storebuffer_state_type        debug_state,
  output logic [storebuffer_depth:0]   debug_count
);

  localparam logic [storebuffer_depth:0] sb_full = (storebuffer_depth + 1)'(sb_entries);

  storebuffer_state_type        state, state_next, op;
  logic [storebuffer_depth-1:0] wptr, rptr;
  logic [storebuffer_depth:0]   count;
  logic                         pend_valid;
  mem_in_type                   pend;

  mem_in_type cur;
  logic       cur_valid, is_fence, is_store, is_load, load_miss;
  logic       retire, accept, load_done, fence_done;
  logic       unused_bits;

  // Handshake: a core request is a one-cycle mem_valid pulse held in pend
  // until mem_ready; dmem_in.mem_valid pulses once per memory transaction and
  // that transaction completes on the first dmem_out.mem_ready seen in the
  // matching busy state (ready in IDLE, e.g. stale after reset, is ignored).
  always_comb begin
    cur       = storebuffer_in.mem_valid ? storebuffer_in : pend;
    cur_valid = storebuffer_in.mem_valid | pend_valid;
    is_fence  = cur_valid & cur.mem_fence;
    is_store  = cur_valid & ~cur.mem_fence & (|cur.mem_wstrb);
    is_load   = cur_valid & ~cur.mem_fence & ~(|cur.mem_wstrb);
    load_miss = is_load & ~(|data_out.hit);
    retire    = (state == SB_STORE) & dmem_out.mem_ready;
    accept    = is_store & ((count != sb_full) | retire);
    load_done  = (state == SB_LOAD) & dmem_out.mem_ready;
    fence_done = (state == SB_FENCE) & dmem_out.mem_ready;
  end

  assign unused_bits = &{1'b0, cur.mem_valid, cur.mem_instr, cur.mem_addr[1:0]};

  always_comb begin
    data_in       = '0;
    data_in.wen   = accept;
    data_in.waddr = wptr;
    data_in.wdata = '{addr: cur.mem_addr[31:2], wdata: cur.mem_wdata, wstrb: cur.mem_wstrb};
    data_in.raddr = rptr;
    data_in.caddr = cur.mem_addr[31:2];
    data_in.valid = occupancy(rptr, count);
  end

  always_comb begin
    state_next = state;
    case (state)
      SB_IDLE: begin
        if (load_miss) begin
          state_next = SB_LOAD;
        end else if (count != '0) begin
          state_next = SB_STORE;
        end else if (is_fence) begin
          state_next = SB_FENCE;
        end
      end
      SB_STORE: if (dmem_out.mem_ready) state_next = SB_IDLE;
      SB_LOAD:  if (dmem_out.mem_ready) state_next = SB_IDLE;
      SB_FENCE: if (dmem_out.mem_ready) state_next = SB_IDLE;
      default:  state_next = SB_IDLE;
    endcase
  end

  // The request issued from IDLE is driven combinationally and then held
  // stable for the whole transaction.
  always_comb begin
    dmem_in = '0;
    op      = (state == SB_IDLE) ? state_next : state;
    case (op)
      SB_STORE: begin
        dmem_in.mem_addr  = {data_out.rdata.addr, 2'b00};
        dmem_in.mem_wdata = data_out.rdata.wdata;
        dmem_in.mem_wstrb = data_out.rdata.wstrb;
      end
      SB_LOAD:  dmem_in.mem_addr  = {cur.mem_addr[31:2], 2'b00};
      SB_FENCE: dmem_in.mem_fence = 1'b1;
      default:  ;
    endcase
    dmem_in.mem_valid = (state == SB_IDLE) && (state_next != SB_IDLE);
  end

  always_comb begin
    storebuffer_out           = '0;
    storebuffer_out.mem_ready = accept | load_done | fence_done;
    if (load_done) begin
      storebuffer_out.mem_rdata = dmem_out.mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= SB_IDLE;
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      pend_valid <= 1'b0;
      pend       <= '0;
    end else begin
      state <= state_next;
      if (accept) wptr <= wptr + 1'b1;
      if (retire) rptr <= rptr + 1'b1;
      case ({accept, retire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      pend_valid <= cur_valid & ~storebuffer_out.mem_ready;
      if (storebuffer_in.mem_valid) begin
        pend <= storebuffer_in;
      end
    end
  end

  assign debug_state = state;
  assign debug_count = count;

endmodule

// File: rtl/storebuffer_data.sv
// Entry array: one write port, one head read port, and a parallel address
// compare of all occupied entries against the outstanding request.
module storebuffer_data
  import storebuffer_wires::*;
(
  input  logic                     clk,
  input  storebuffer_data_in_type  data_in,
  output storebuffer_data_out_type data_out
);

  storebuffer_entry_type entries [sb_entries];

  always_ff @(posedge clk) begin
    if (data_in.wen) begin
      entries[data_in.waddr] <= data_in.wdata;
    end
  end

  always_comb begin
    data_out       = '0;
    data_out.rdata = entries[data_in.raddr];
    for (int i = 0; i < sb_entries; i++) begin
      data_out.hit[i] = data_in.valid[i] && (entries[i].addr == data_in.caddr);
    end
  end

endmodule

// File: rtl/storebuffer.sv
// Posted-write buffer between the core data port and data memory: wires the
// control block to the entry array.
module storebuffer
  import storebuffer_wires::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  mem_in_type                 storebuffer_in,
  output mem_out_type                storebuffer_out,
  input  mem_out_type                dmem_out,
  output mem_in_type                 dmem_in,
  output storebuffer_state_type      debug_state,
  output logic [storebuffer_depth:0] debug_count
);

  storebuffer_data_in_type  data_in;
  storebuffer_data_out_type data_out;

  storebuffer_ctrl u_ctrl (
    .clk             (clk),
    .rst             (rst),
    .storebuffer_in  (storebuffer_in),
    .storebuffer_out (storebuffer_out),
    .dmem_out        (dmem_out),
    .dmem_in         (dmem_in),
    .data_in         (data_in),
    .data_out        (data_out),
    .debug_state     (debug_state),
    .debug_count     (debug_count)
  );

  storebuffer_data u_data (
    .clk      (clk),
    .data_in  (data_in),
    .data_out (data_out)
  );

endmodule

// File: tb/tb_storebuffer.sv
// Directed bench for storebuffer: hand-computed expectations, store order
// tracked in an expected queue, one summary line at the end.
module tb_storebuffer;
  import storebuffer_wires::*;

  logic                       clk;
  logic                       rst;
  mem_in_type                 sb_in;
  mem_out_type                sb_out;
  mem_out_type                dmem_out;
  mem_in_type                 dmem_in;
  storebuffer_state_type      debug_state;
  logic [storebuffer_depth:0] debug_count;

  int errors = 0;
  int checks = 0;
  logic [67:0] exp_q[$];

  storebuffer dut (
    .clk             (clk),
    .rst             (rst),
    .storebuffer_in  (sb_in),
    .storebuffer_out (sb_out),
    .dmem_out        (dmem_out),
    .dmem_in         (dmem_in),
    .debug_state     (debug_state),
    .debug_count     (debug_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs return to idle, then settle before new drive.
  task automatic step();
    @(posedge clk);
    #1;
    sb_in    = '0;
    dmem_out = '0;
    #1;
  endtask

  task automatic core_req(input logic fence, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wstrb);
    sb_in           = '0;
    sb_in.mem_valid = 1'b1;
    sb_in.mem_fence = fence;
    sb_in.mem_addr  = addr;
    sb_in.mem_wdata = wdata;
    sb_in.mem_wstrb = wstrb;
    #1;
  endtask

  task automatic store(input string tag, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic ack);
    core_req(1'b0, addr, wdata, 4'hF);
    exp_q.push_back({addr, wdata, 4'hF});
    check({tag, "_ack"}, 32'(sb_out.mem_ready), 32'(ack));
  endtask

  task automatic check_issue(input string tag);
    logic [67:0] e;
    check({tag, "_valid"}, 32'(dmem_in.mem_valid), 32'd1);
    check({tag, "_qsize"}, 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_addr"},  dmem_in.mem_addr,         e[67:36]);
      check({tag, "_wdata"}, dmem_in.mem_wdata,        e[35:4]);
      check({tag, "_wstrb"}, 32'(dmem_in.mem_wstrb),   32'(e[3:0]));
    end
  endtask

  // Wait (bounded) for the next store issue, check it, then retire it.
  task automatic drain_one(input string tag);
    int n = 0;
    while (!dmem_in.mem_valid && n < 8) begin
      step();
      n++;
    end
    check_issue(tag);
    step();
    dmem_out.mem_ready = 1'b1;
    #1;
    check({tag, "_no_core_ready"}, 32'(sb_out.mem_ready), 32'd0);
    step();
  endtask

  initial begin
    rst      = 1'b0;
    sb_in    = '0;
    dmem_out = '0;
    @(posedge clk);
    @(posedge clk);
    #2;
    check("rst_core_ready", 32'(sb_out.mem_ready), 32'd0);
    check("rst_core_rdata", sb_out.mem_rdata, 32'd0);
    check("rst_dmem_in",    32'(|dmem_in), 32'd0);
    check("rst_count",      32'(debug_count), 32'd0);
    check("rst_state",      32'(debug_state), 32'(SB_IDLE));
    rst = 1'b1;
    step();

    // single store with empty queue
    store("t1_store", 32'h0000_1000, 32'hDEAD_BEEF, 1'b1);
    check("t1_rdata", sb_out.mem_rdata, 32'd0);
    check("t1_no_issue_yet", 32'(dmem_in.mem_valid), 32'd0);
    step();
    check("t1_count", 32'(debug_count), 32'd1);
    drain_one("t1_drain");
    check("t1_count_after", 32'(debug_count), 32'd0);
    check("t1_state_after", 32'(debug_state), 32'(SB_IDLE));

    // five stores, memory held off: fifth acked on first retire
    store("t2_s0", 32'h0000_0100, 32'h0000_0010, 1'b1);
    step();
    store("t2_s1", 32'h0000_0104, 32'h0000_0011, 1'b1);
    check_issue("t2_issue0");
    step();
    store("t2_s2", 32'h0000_0108, 32'h0000_0012, 1'b1);
    step();
    store("t2_s3", 32'h0000_010C, 32'h0000_0013, 1'b1);
    step();
    check("t2_full", 32'(debug_count), 32'd4);
    store("t2_s4", 32'h0000_0110, 32'h0000_0014, 1'b0);
    step();
    check("t2_s4_held", 32'(sb_out.mem_ready), 32'd0);
    step();
    dmem_out.mem_ready = 1'b1;
    #1;
    check("t2_s4_ack_on_retire", 32'(sb_out.mem_ready), 32'd1);
    step();
    check("t2_count_unchanged", 32'(debug_count), 32'd4);
    for (int i = 1; i < 5; i++) drain_one($sformatf("t2_drain%0d", i));
    check("t2_count_empty", 32'(debug_count), 32'd0);

    // load hitting a queued store waits for it to retire
    store("t3_store", 32'h0000_2000, 32'h0000_A5A5, 1'b1);
    step();
    core_req(1'b0, 32'h0000_2002, 32'd0, 4'h0);
    check_issue("t3_store_issue");
    check("t3_load_not_ready", 32'(sb_out.mem_ready), 32'd0);
    step();
    check("t3_no_issue_busy", 32'(dmem_in.mem_valid), 32'd0);
    step();
    dmem_out.mem_ready = 1'b1;
    #1;
    check("t3_no_ack_on_store", 32'(sb_out.mem_ready), 32'd0);
    step();
    check("t3_load_valid", 32'(dmem_in.mem_valid), 32'd1);
    check("t3_load_addr",  dmem_in.mem_addr, 32'h0000_2000);
    check("t3_load_wstrb", 32'(dmem_in.mem_wstrb), 32'd0);
    step();
    dmem_out.mem_ready = 1'b1;
    dmem_out.mem_rdata = 32'hCAFE_F00D;
    #1;
    check("t3_load_ready", 32'(sb_out.mem_ready), 32'd1);
    check("t3_load_rdata", sb_out.mem_rdata, 32'hCAFE_F00D);
    step();
    check("t3_ready_drop", 32'(sb_out.mem_ready), 32'd0);

    // load miss bypasses a queued store
    store("t4_store", 32'h0000_4000, 32'h0000_0044, 1'b1);
    step();
    core_req(1'b0, 32'h0000_3000, 32'd0, 4'h0);
    check("t4_miss_valid", 32'(dmem_in.mem_valid), 32'd1);
    check("t4_miss_addr",  dmem_in.mem_addr, 32'h0000_3000);
    check("t4_miss_wstrb", 32'(dmem_in.mem_wstrb), 32'd0);
    step();
    dmem_out.mem_ready = 1'b1;
    dmem_out.mem_rdata = 32'h1234_5678;
    #1;
    check("t4_load_ready", 32'(sb_out.mem_ready), 32'd1);
    check("t4_load_rdata", sb_out.mem_rdata, 32'h1234_5678);
    step();
    drain_one("t4_drain");
    check("t4_count", 32'(debug_count), 32'd0);

    // fence drains three stores, then goes to memory
    store("t5_sa", 32'h0000_0500, 32'h0000_00A0, 1'b1);
    step();
    store("t5_sb", 32'h0000_0504, 32'h0000_00B0, 1'b1);
    check_issue("t5_issue_a");
    step();
    store("t5_sc", 32'h0000_0508, 32'h0000_00C0, 1'b1);
    step();
    core_req(1'b1, 32'd0, 32'd0, 4'h0);
    check("t5_fence_wait", 32'(sb_out.mem_ready), 32'd0);
    step();
    dmem_out.mem_ready = 1'b1;
    #1;
    check("t5_retire_a_no_ack", 32'(sb_out.mem_ready), 32'd0);
    step();
    drain_one("t5_drain_b");
    drain_one("t5_drain_c");
    check("t5_fence_valid", 32'(dmem_in.mem_valid), 32'd1);
    check("t5_fence_flag",  32'(dmem_in.mem_fence), 32'd1);
    check("t5_fence_instr", 32'(dmem_in.mem_instr), 32'd0);
    check("t5_fence_no_ack", 32'(sb_out.mem_ready), 32'd0);
    step();
    check("t5_fence_hold", 32'(sb_out.mem_ready), 32'd0);
    step();
    dmem_out.mem_ready = 1'b1;
    #1;
    check("t5_fence_ack", 32'(sb_out.mem_ready), 32'd1);
    step();
    check("t5_fence_done", 32'(sb_out.mem_ready), 32'd0);
    check("t5_state_idle", 32'(debug_state), 32'(SB_IDLE));

    // reset with two entries queued and a store outstanding
    store("t6_sx", 32'h0000_0600, 32'h0000_0066, 1'b1);
    step();
    store("t6_sy", 32'h0000_0604, 32'h0000_0067, 1'b1);
    check("t6_issue_x", dmem_in.mem_addr, 32'h0000_0600);
    step();
    check("t6_count_pre", 32'(debug_count), 32'd2);
    rst = 1'b0;
    #1;
    check("t6_rst_dmem_in",    32'(|dmem_in), 32'd0);
    check("t6_rst_core_ready", 32'(sb_out.mem_ready), 32'd0);
    check("t6_rst_count",      32'(debug_count), 32'd0);
    check("t6_rst_state",      32'(debug_state), 32'(SB_IDLE));
    step();
    rst = 1'b1;
    exp_q.delete();
    step();
    dmem_out.mem_ready = 1'b1;
    dmem_out.mem_rdata = 32'h5555_AAAA;
    #1;
    check("t6_stale_core_ready", 32'(sb_out.mem_ready), 32'd0);
    check("t6_stale_dmem_valid", 32'(dmem_in.mem_valid), 32'd0);
    step();
    check("t6_stale_count", 32'(debug_count), 32'd0);
    check("t6_stale_state", 32'(debug_state), 32'(SB_IDLE));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
